// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared fetch state encoding and PC constants
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_VALID,
        S_DRAIN,
        S_FAULT
    } fetch_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with reset/redirect/increment/hold select
module fetch_pc_reg
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    // Redirect outranks the sequential increment; wrap is plain modulo-2^32 addition.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + PC_INC;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM and decode output registers; FETCH_ALIGN_CHECK_EN enables misaligned-redirect fault
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic [31:0]  target;
    logic         bad_target;
    logic         redir_take;
    logic         pc_advance;
    logic         fault_pending;
    logic         fault_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_target = redirect_valid && (redirect_addr[1:0] != 2'b00) && (state != S_FAULT);
    assign target     = redirect_addr;
`else
    assign bad_target = 1'b0;
    assign target     = redirect_addr & ~32'h3;
`endif

    assign redir_take  = redirect_valid && !bad_target && !fault_pending && (state != S_FAULT);
    assign pc_advance  = (state == S_REQ) && imem_ack && !redirect_valid;
    assign imem_req    = !rst && ((state == S_REQ) || (state == S_DRAIN));
    // The abandoned request keeps its own address after pc has moved to the new target.
    assign imem_addr   = (state == S_DRAIN) ? drain_addr : pc;
    assign fetch_fault = fault_q;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redir_take),
        .advance (pc_advance),
        .target  (target),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            instr_valid   <= 1'b0;
            instr         <= 32'h0;
            instr_pc      <= 32'h0;
            drain_addr    <= RESET_PC;
            fault_pending <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            if (bad_target) begin
                fault_q <= 1'b1;
            end
            case (state)
                S_REQ: begin
                    if (bad_target) begin
                        if (imem_ack) begin
                            state <= S_FAULT;
                        end else begin
                            fault_pending <= 1'b1;
                            drain_addr    <= pc;
                            state         <= S_DRAIN;
                        end
                    end else if (redir_take) begin
                        if (!imem_ack) begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (bad_target) begin
                        instr_valid <= 1'b0;
                        state       <= S_FAULT;
                    end else if (redir_take || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bad_target) begin
                        fault_pending <= 1'b1;
                    end
                    if (imem_ack) begin
                        state <= (fault_pending || bad_target) ? S_FAULT : S_REQ;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench with random-latency SRAM model for instr_fetch_unit
module tb_instr_fetch_unit;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int compared = 0;
    int mismatched = 0;
    int accepted = 0;
    int wait_cfg = 0;
    bit rand_wait = 1'b0;

    logic [31:0] exp_q[$];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SRAM model: answers each request after a fixed or random number of wait cycles.
    bit busy = 1'b0;
    int cnt = 0;
    always @(negedge clk) begin
        if (rst || !imem_req) begin
            imem_ack = 1'b0;
            busy     = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = rand_wait ? int'($urandom_range(0, 4)) : wait_cfg;
            end
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom();
                cnt--;
            end
        end
    end

    // Monitor: protocol checks and in-order scoreboard of delivered instructions.
    bit          pend_req = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_instr = 32'h0;
    logic [31:0] pend_pc = 32'h0;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(DEFAULT_RESET_PC);
            pend_req   = 1'b0;
            pend_valid = 1'b0;
        end else begin
            if (pend_req)
                check("req_held", {imem_req, imem_addr}, {1'b1, pend_addr});
            if (imem_req)
                check("addr_align", imem_addr[1:0], 2'b00);
            if (pend_valid)
                check("instr_held", {instr_valid, instr, instr_pc}, {1'b1, pend_instr, pend_pc});
            if (redirect_valid) begin
                exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (redirect_addr[1:0] == 2'b00)
                    exp_q.push_back(redirect_addr);
`else
                exp_q.push_back({redirect_addr[31:2], 2'b00});
`endif
            end else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", {1'b1, instr_pc}, {1'b0, instr_pc});
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_instr_pc", instr_pc, e);
                    check("sb_instr", instr, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                    accepted++;
                end
            end
            pend_req   = imem_req && !imem_ack;
            pend_addr  = imem_addr;
            pend_valid = instr_valid && !instr_ready && !redirect_valid;
            pend_instr = instr;
            pend_pc    = instr_pc;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (instr_valid) break;
            cyc();
            at_sample();
        end
        check(name, instr_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int n;
        logic [31:0] got [2];

        // Reset values
        rst = 1'b1;
        repeat (3) cyc();
        at_sample();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fault", fetch_fault, 1'b0);

        // Zero-wait SRAM, decode always ready
        cyc();
        rst = 1'b0;
        instr_ready = 1'b1;
        at_sample();
        check("first_req", {imem_req, imem_addr}, {1'b1, DEFAULT_RESET_PC});
        for (int i = 1; i < 8; i++) begin
            cyc();
            at_sample();
            check("zw_valid_cadence", instr_valid, (i % 2) == 1);
            if (instr_valid)
                check("zw_instr_pc", instr_pc, 32'(i / 2) * 32'd4);
        end

        // 3-wait SRAM, decode stalls for 5 cycles
        cyc();
        rst = 1'b1;
        instr_ready = 1'b0;
        wait_cfg = 3;
        cyc();
        rst = 1'b0;
        at_sample();
        wait_valid("w3_timeout");
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {instr_valid, imem_req, instr_pc, instr}, {1'b1, 1'b0, 32'h0, mem_word(32'h0)});
            cyc();
            at_sample();
        end
        cyc();
        instr_ready = 1'b1;
        at_sample();
        cyc();
        instr_ready = 1'b0;
        at_sample();
        check("after_accept_req", {imem_req, imem_addr}, {1'b1, 32'h4});

        // Redirect while VALID with ready high drops the held word
        wait_valid("pre_redir_timeout");
        acc0 = accepted;
        cyc();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0100;
        at_sample();
        cyc();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        at_sample();
        check("redir_valid_drop", {instr_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
        check("redir_not_accepted", accepted, acc0);

        // Redirect during a 4-wait request: old request drained
        wait_cfg = 4;
        wait_valid("w_100_timeout");
        check("deliver_100", instr_pc, 32'h100);
        cyc();
        redirect_valid = 1'b1;
        redirect_addr = 32'h8;
        at_sample();
        cyc();
        redirect_valid = 1'b0;
        at_sample();
        check("req_at_8", {imem_req, imem_addr}, {1'b1, 32'h8});
        cyc();
        redirect_valid = 1'b1;
        redirect_addr = 32'h200;
        at_sample();
        cyc();
        redirect_valid = 1'b0;
        at_sample();
        for (int i = 0; i < 10; i++) begin
            check("drain_hold", {imem_req, imem_addr}, {1'b1, 32'h8});
            if (imem_ack) break;
            cyc();
            at_sample();
        end
        cyc();
        at_sample();
        check("post_drain_req", {imem_req, imem_addr}, {1'b1, 32'h200});
        instr_ready = 1'b1;
        wait_valid("w_200_timeout");
        check("deliver_200", instr_pc, 32'h200);

        // PC wrap at top of address space
        cyc();
        instr_ready = 1'b0;
        wait_cfg = 0;
        at_sample();
        wait_valid("pre_wrap_timeout");
        cyc();
        redirect_valid = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        instr_ready = 1'b1;
        at_sample();
        cyc();
        redirect_valid = 1'b0;
        n = 0;
        got[0] = 32'h1;
        got[1] = 32'h1;
        for (int i = 0; i < 20; i++) begin
            at_sample();
            if (instr_valid && instr_ready) begin
                got[n] = instr_pc;
                n++;
            end
            if (n == 2) break;
            cyc();
        end
        check("wrap_pc0", got[0], 32'hFFFF_FFFC);
        check("wrap_pc1", got[1], 32'h0000_0000);

        // Misaligned redirect
        cyc();
        instr_ready = 1'b0;
        at_sample();
        wait_valid("pre_misalign_timeout");
        cyc();
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0102;
        at_sample();
        cyc();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        at_sample();
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            check("fault_state", {fetch_fault, imem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
            cyc();
            at_sample();
        end
`else
        check("misalign_ignored", {fetch_fault, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
        wait_valid("misalign_timeout");
        check("misalign_deliver", instr_pc, 32'h100);
`endif

        // Random traffic with random SRAM latency and a mid-run reset
        cyc();
        rst = 1'b1;
        rand_wait = 1'b1;
        cyc();
        rst = 1'b0;
        acc0 = accepted;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = (i >= 1500 && i < 1502);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_addr = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            else
                redirect_addr = $urandom() & 32'h0000_FFFC;
`ifndef FETCH_ALIGN_CHECK_EN
            redirect_addr = redirect_addr | $urandom_range(0, 3);
`endif
        end
        cyc();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        repeat (3) cyc();
        check("random_progress", accepted - acc0 > 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
